// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared states, instruction classes and decode constants
// for the multi-cycle LEGv8 controller.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_FAULT  = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      CL_AND, CL_ORR, CL_ADD, CL_SUB, CL_ADDI, CL_SUBI, CL_CBZ, CL_B,
      CL_LDUR, CL_STUR, CL_MOVZ, CL_ILLEGAL, CL_NONE
   } class_t;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   localparam logic [1:0] SIGN_I  = 2'b00;
   localparam logic [1:0] SIGN_D  = 2'b01;
   localparam logic [1:0] SIGN_B  = 2'b10;
   localparam logic [1:0] SIGN_CB = 2'b11;

   // Opcode wildcard patterns: a bit takes part in the match only where mask is 1.
   typedef struct packed {
      logic [10:0] mask;
      logic [10:0] val;
   } op_pat_t;

   localparam op_pat_t PAT_AND  = '{mask: 11'b01111111000, val: 11'b00001010000};
   localparam op_pat_t PAT_ORR  = '{mask: 11'b01111111000, val: 11'b00101010000};
   localparam op_pat_t PAT_ADD  = '{mask: 11'b01011111000, val: 11'b00001011000};
   localparam op_pat_t PAT_SUB  = '{mask: 11'b01011111000, val: 11'b01001011000};
   localparam op_pat_t PAT_ADDI = '{mask: 11'b01011111000, val: 11'b00010001000};
   localparam op_pat_t PAT_SUBI = '{mask: 11'b01011111000, val: 11'b01010001000};
   localparam op_pat_t PAT_CBZ  = '{mask: 11'b01111110000, val: 11'b00110100000};
   localparam op_pat_t PAT_B    = '{mask: 11'b01111100000, val: 11'b00010100000};
   localparam op_pat_t PAT_LDUR = '{mask: 11'b00111111111, val: 11'b00111000010};
   localparam op_pat_t PAT_STUR = '{mask: 11'b00111111111, val: 11'b00111000000};
   localparam op_pat_t PAT_MOVZ = '{mask: 11'b11111111100, val: 11'b11010010100};

   function automatic logic op_match(input logic [10:0] op, input op_pat_t p);
      return (op & p.mask) == p.val;
   endfunction

endpackage

// File: rtl/mc_opcode_classify.sv
// rtl/mc_opcode_classify.sv - combinational opcode to instruction-class decode,
// first matching pattern wins.
module mc_opcode_classify
   import mc_ctrl_pkg::*;
(
   input  logic [10:0] i_opcode,
   output class_t      o_class
);

   always_comb begin
      o_class = CL_ILLEGAL;
      if      (op_match(i_opcode, PAT_AND))  o_class = CL_AND;
      else if (op_match(i_opcode, PAT_ORR))  o_class = CL_ORR;
      else if (op_match(i_opcode, PAT_ADD))  o_class = CL_ADD;
      else if (op_match(i_opcode, PAT_SUB))  o_class = CL_SUB;
      else if (op_match(i_opcode, PAT_ADDI)) o_class = CL_ADDI;
      else if (op_match(i_opcode, PAT_SUBI)) o_class = CL_SUBI;
      else if (op_match(i_opcode, PAT_CBZ))  o_class = CL_CBZ;
      else if (op_match(i_opcode, PAT_B))    o_class = CL_B;
      else if (op_match(i_opcode, PAT_LDUR)) o_class = CL_LDUR;
      else if (op_match(i_opcode, PAT_STUR)) o_class = CL_STUR;
      else if (op_match(i_opcode, PAT_MOVZ)) o_class = CL_MOVZ;
   end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout and sticky FAULT.
// Define PERF_CNT_EN to add the retired[31:0] counter of pcwrite cycles.
module multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [10:0] opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        imem_req,
   output logic        irwrite,
   output logic        pcwrite,
   output logic        pcsrc,
   output logic        reg2loc,
   output logic        alusrc,
   output logic        mem2reg,
   output logic        regwrite,
   output logic        memread,
   output logic        memwrite,
   output logic        movz,
   output logic [3:0]  aluop,
   output logic [1:0]  signop,
   output logic [1:0]  shamt,
   output logic        fault,
`ifdef PERF_CNT_EN
   output logic [31:0] retired,
`endif
   output logic [2:0]  state
);

   localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            r_state;
   class_t            r_class;
   logic [1:0]        r_shamt;
   logic [WAIT_W-1:0] r_wait;

   class_t            w_class;
   logic              w_timeout;
   logic [3:0]        w_aluop;
   logic [1:0]        w_signop;
   logic              w_is_imm;
   logic              w_reg2loc;

   mc_opcode_classify u_classify (
      .i_opcode (opcode),
      .o_class  (w_class)
   );

   // The cycle that would be the (MEM_TIMEOUT+1)-th wait goes to FAULT instead.
   assign w_timeout = TIMEOUT_EN && (r_wait == WAIT_LAST);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state <= ST_FETCH;
         r_class <= CL_NONE;
         r_shamt <= 2'b00;
         r_wait  <= '0;
      end else begin
         r_wait <= '0;
         case (r_state)
            ST_FETCH: begin
               if (mem_ready)      r_state <= ST_DECODE;
               else if (w_timeout) r_state <= ST_FAULT;
               else                r_wait  <= r_wait + 1'b1;
            end
            ST_DECODE: begin
               r_class <= w_class;
               r_shamt <= (w_class == CL_MOVZ) ? opcode[1:0] : 2'b00;
               r_state <= (w_class == CL_ILLEGAL) ? ST_FAULT : ST_EXEC;
            end
            ST_EXEC: begin
               case (r_class)
                  CL_CBZ, CL_B:     r_state <= ST_FETCH;
                  CL_LDUR, CL_STUR: r_state <= ST_MEM;
                  default:          r_state <= ST_WB;
               endcase
            end
            ST_MEM: begin
               if (mem_ready)      r_state <= (r_class == CL_STUR) ? ST_FETCH : ST_WB;
               else if (w_timeout) r_state <= ST_FAULT;
               else                r_wait  <= r_wait + 1'b1;
            end
            ST_WB:    r_state <= ST_FETCH;
            default:  r_state <= ST_FAULT;
         endcase
      end
   end

   always_comb begin
      w_aluop  = ALU_AND;
      w_signop = SIGN_I;
      case (r_class)
         CL_ORR:           w_aluop = ALU_OR;
         CL_ADD, CL_ADDI:  w_aluop = ALU_ADD;
         CL_SUB, CL_SUBI:  w_aluop = ALU_SUB;
         CL_LDUR, CL_STUR: begin w_aluop = ALU_ADD;   w_signop = SIGN_D;  end
         CL_CBZ:           begin w_aluop = ALU_PASSB; w_signop = SIGN_CB; end
         CL_MOVZ:          w_aluop = ALU_PASSB;
         CL_B:             w_signop = SIGN_B;
         default:          ;
      endcase
   end

   assign w_is_imm  = (r_class == CL_ADDI) || (r_class == CL_SUBI) ||
                      (r_class == CL_LDUR) || (r_class == CL_STUR);
   assign w_reg2loc = (r_class == CL_CBZ) || (r_class == CL_STUR) || (r_class == CL_MOVZ);

   // Reset forces every strobe low immediately so an aborted instruction writes nothing.
   always_comb begin
      imem_req = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      pcsrc    = 1'b0;
      reg2loc  = 1'b0;
      alusrc   = 1'b0;
      mem2reg  = 1'b0;
      regwrite = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      movz     = 1'b0;
      aluop    = 4'b0000;
      signop   = 2'b00;
      shamt    = 2'b00;
      fault    = 1'b0;
      state    = r_state;
      if (!reset) begin
         case (r_state)
            ST_FETCH: begin
               imem_req = 1'b1;
               irwrite  = mem_ready;
            end
            ST_EXEC: begin
               alusrc  = w_is_imm;
               aluop   = w_aluop;
               signop  = w_signop;
               reg2loc = w_reg2loc;
               movz    = (r_class == CL_MOVZ);
               shamt   = r_shamt;
               if (r_class == CL_CBZ) begin
                  pcwrite = 1'b1;
                  pcsrc   = zero;
               end else if (r_class == CL_B) begin
                  pcwrite = 1'b1;
                  pcsrc   = 1'b1;
               end
            end
            ST_MEM: begin
               alusrc   = w_is_imm;
               aluop    = w_aluop;
               signop   = w_signop;
               memread  = (r_class == CL_LDUR);
               memwrite = (r_class == CL_STUR);
               pcwrite  = mem_ready && (r_class == CL_STUR);
            end
            ST_WB: begin
               regwrite = 1'b1;
               pcwrite  = 1'b1;
               mem2reg  = (r_class == CL_LDUR);
               movz     = (r_class == CL_MOVZ);
               shamt    = r_shamt;
            end
            ST_FAULT: fault = 1'b1;
            default:  ;
         endcase
      end
   end

`ifdef PERF_CNT_EN
   logic [31:0] r_retired;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset)        r_retired <= 32'd0;
      else if (pcwrite) r_retired <= r_retired + 32'd1;
   end

   assign retired = r_retired;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - decode table, directed corner sequences and random
// cycle-by-cycle comparison against an instruction-phase reference model.
module tb_multicycle_control;

   localparam int TO = 4;
   localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4, PH_X = 7;
   localparam int C_AND = 0, C_ORR = 1, C_ADD = 2, C_SUB = 3, C_ADDI = 4, C_SUBI = 5;
   localparam int C_CBZ = 6, C_B = 7, C_LDUR = 8, C_STUR = 9, C_MOVZ = 10, C_ILL = 11;

   logic        CLK = 1'b0;
   logic        reset;
   logic [10:0] opcode;
   logic        zero, mem_ready;
   logic        imem_req, irwrite, pcwrite, pcsrc, reg2loc, alusrc, mem2reg;
   logic        regwrite, memread, memwrite, movz, fault;
   logic [3:0]  aluop;
   logic [1:0]  signop, shamt;
   logic [2:0]  state;
`ifdef PERF_CNT_EN
   logic [31:0] retired;
`endif
   logic [22:0] w_act;

   int checks = 0;
   int failures = 0;

   string pats [0:10] = '{"?0001010???", "?0101010???", "?0?01011???", "?1?01011???",
                          "?0?10001???", "?1?10001???", "?011010????", "?00101?????",
                          "??111000010", "??111000000", "110100101??"};

   int          m_ph, m_wait, m_c;
   logic [1:0]  m_sh;
   logic [31:0] m_ret;

   multicycle_control #(.MEM_TIMEOUT(TO)) dut (
      .CLK(CLK), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .imem_req(imem_req), .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc),
      .reg2loc(reg2loc), .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite),
      .memread(memread), .memwrite(memwrite), .movz(movz), .aluop(aluop),
      .signop(signop), .shamt(shamt), .fault(fault),
`ifdef PERF_CNT_EN
      .retired(retired),
`endif
      .state(state)
   );

   always #5 CLK = ~CLK;

   assign w_act = {imem_req, irwrite, pcwrite, pcsrc, reg2loc, alusrc, mem2reg, regwrite,
                   memread, memwrite, movz, aluop, signop, shamt, fault, state};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int classify_ref(input logic [10:0] op);
      for (int k = 0; k < 11; k++) begin
         bit ok = 1'b1;
         for (int b = 0; b < 11; b++) begin
            byte c = pats[k][b];
            if (c == 8'h30 && op[10-b] !== 1'b0) ok = 1'b0;
            if (c == 8'h31 && op[10-b] !== 1'b1) ok = 1'b0;
         end
         if (ok) return k;
      end
      return C_ILL;
   endfunction

   function automatic logic [10:0] gen_op(input int k);
      logic [10:0] op;
      for (int b = 0; b < 11; b++) begin
         byte c = pats[k][b];
         op[10-b] = (c == 8'h3F) ? 1'($urandom) : (c == 8'h31);
      end
      return op;
   endfunction

   function automatic logic [22:0] exp_out(input int ph, input int c, input logic z,
                                           input logic rdy, input logic [1:0] sh);
      logic imem = 0, irw = 0, pcw = 0, pcs = 0, r2l = 0, asrc = 0, m2r = 0;
      logic rw = 0, mr = 0, mw = 0, mz = 0, flt = 0;
      logic [3:0] alu = 4'd0, alu_c;
      logic [1:0] sop = 2'd0, sop_c, shm = 2'd0;
      alu_c = (c == C_ORR) ? 4'd1 :
              (c == C_ADD || c == C_ADDI || c == C_LDUR || c == C_STUR) ? 4'd2 :
              (c == C_SUB || c == C_SUBI) ? 4'd6 :
              (c == C_CBZ || c == C_MOVZ) ? 4'd7 : 4'd0;
      sop_c = (c == C_LDUR || c == C_STUR) ? 2'd1 : (c == C_B) ? 2'd2 :
              (c == C_CBZ) ? 2'd3 : 2'd0;
      case (ph)
         PH_F: begin imem = 1; irw = rdy; end
         PH_E: begin
            asrc = (c == C_ADDI || c == C_SUBI || c == C_LDUR || c == C_STUR);
            alu = alu_c; sop = sop_c;
            r2l = (c == C_CBZ || c == C_STUR || c == C_MOVZ);
            mz = (c == C_MOVZ);
            shm = (c == C_MOVZ) ? sh : 2'd0;
            if (c == C_CBZ) begin pcw = 1; pcs = z; end
            if (c == C_B)   begin pcw = 1; pcs = 1; end
         end
         PH_M: begin
            asrc = 1; alu = alu_c; sop = sop_c;
            mr = (c == C_LDUR); mw = (c == C_STUR);
            pcw = rdy && (c == C_STUR);
         end
         PH_W: begin
            rw = 1; pcw = 1; m2r = (c == C_LDUR);
            mz = (c == C_MOVZ); shm = (c == C_MOVZ) ? sh : 2'd0;
         end
         PH_X: flt = 1;
         default: ;
      endcase
      return {imem, irw, pcw, pcs, r2l, asrc, m2r, rw, mr, mw, mz, alu, sop, shm, flt, 3'(ph)};
   endfunction

   task automatic model_step();
      case (m_ph)
         PH_F: begin
            if (mem_ready) begin m_ph = PH_D; m_wait = 0; end
            else begin m_wait++; if (m_wait == TO) begin m_ph = PH_X; m_wait = 0; end end
         end
         PH_D: begin
            m_c  = classify_ref(opcode);
            m_sh = (m_c == C_MOVZ) ? opcode[1:0] : 2'd0;
            m_ph = (m_c == C_ILL) ? PH_X : PH_E;
         end
         PH_E: m_ph = (m_c == C_CBZ || m_c == C_B) ? PH_F :
                      (m_c == C_LDUR || m_c == C_STUR) ? PH_M : PH_W;
         PH_M: begin
            if (mem_ready) begin m_ph = (m_c == C_STUR) ? PH_F : PH_W; m_wait = 0; end
            else begin m_wait++; if (m_wait == TO) begin m_ph = PH_X; m_wait = 0; end end
         end
         PH_W: m_ph = PH_F;
         default: ;
      endcase
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_ready = 1'b0;
      zero = 1'b0;
      @(negedge CLK);
      chk("reset_outputs", 64'(w_act), 64'd0);
      @(posedge CLK); #1;
      reset = 1'b0;
      m_ph = PH_F; m_wait = 0; m_c = C_ILL; m_sh = 2'd0; m_ret = 32'd0;
   endtask

   task automatic run_instr(input logic [10:0] op, input logic z, output int cyc,
                            output logic [3:0] ex_alu, output logic [1:0] ex_sop,
                            output logic ex_pcs, output logic rw_seen, output logic [2:0] fin);
      opcode = op; zero = z; mem_ready = 1'b1;
      cyc = 0; ex_alu = 4'd0; ex_sop = 2'd0; ex_pcs = 1'b0; rw_seen = 1'b0;
      do begin
         @(negedge CLK);
         if (state == 3'd2) begin ex_alu = aluop; ex_sop = signop; ex_pcs = pcsrc; end
         if (regwrite) rw_seen = 1'b1;
         cyc++;
         @(posedge CLK); #1;
      end while (state != 3'd0 && state != 3'd7 && cyc < 20);
      fin = state;
   endtask

   typedef struct {
      string       nm;
      logic [10:0] op;
      logic        z;
      int          cpi;
      logic [3:0]  alu;
      logic [1:0]  sop;
      logic        pcs;
      logic        rw;
      logic [2:0]  fin;
   } vec_t;

   vec_t vecs [0:12];

   initial begin
      int          cyc;
      logic [3:0]  ea;
      logic [1:0]  es;
      logic        ep, rws;
      logic [2:0]  fin;
      int          add_st [0:4] = '{0, 1, 2, 4, 0};
      int          mr_cnt, fault_cyc;
      logic        m2r_seen;

      vecs[0]  = '{"add",   11'b10001011000, 1'b0, 4, 4'd2, 2'd0, 1'b0, 1'b1, 3'd0};
      vecs[1]  = '{"and",   11'b10001010000, 1'b0, 4, 4'd0, 2'd0, 1'b0, 1'b1, 3'd0};
      vecs[2]  = '{"orr",   11'b10101010000, 1'b0, 4, 4'd1, 2'd0, 1'b0, 1'b1, 3'd0};
      vecs[3]  = '{"sub",   11'b11001011000, 1'b0, 4, 4'd6, 2'd0, 1'b0, 1'b1, 3'd0};
      vecs[4]  = '{"addi",  11'b10010001000, 1'b0, 4, 4'd2, 2'd0, 1'b0, 1'b1, 3'd0};
      vecs[5]  = '{"subi",  11'b11010001000, 1'b0, 4, 4'd6, 2'd0, 1'b0, 1'b1, 3'd0};
      vecs[6]  = '{"cbz_z1",11'b10110100000, 1'b1, 3, 4'd7, 2'd3, 1'b1, 1'b0, 3'd0};
      vecs[7]  = '{"cbz_z0",11'b10110100111, 1'b0, 3, 4'd7, 2'd3, 1'b0, 1'b0, 3'd0};
      vecs[8]  = '{"b",     11'b00010100000, 1'b0, 3, 4'd0, 2'd2, 1'b1, 1'b0, 3'd0};
      vecs[9]  = '{"ldur",  11'b11111000010, 1'b0, 5, 4'd2, 2'd1, 1'b0, 1'b1, 3'd0};
      vecs[10] = '{"stur",  11'b11111000000, 1'b0, 4, 4'd2, 2'd1, 1'b0, 1'b0, 3'd0};
      vecs[11] = '{"movz",  11'b11010010101, 1'b0, 4, 4'd7, 2'd0, 1'b0, 1'b1, 3'd0};
      vecs[12] = '{"illeg", 11'b00000000000, 1'b0, 2, 4'd0, 2'd0, 1'b0, 1'b0, 3'd7};

      opcode = 11'd0;
      do_reset();
      @(negedge CLK);
      chk("post_reset_state", 64'(state), 64'd0);
      chk("post_reset_fault", 64'(fault), 64'd0);
      @(posedge CLK); #1;

      for (int i = 0; i < 13; i++) begin
         do_reset();
         run_instr(vecs[i].op, vecs[i].z, cyc, ea, es, ep, rws, fin);
         chk({vecs[i].nm, "_cycles"}, 64'(cyc), 64'(vecs[i].cpi));
         chk({vecs[i].nm, "_aluop"},  64'(ea),  64'(vecs[i].alu));
         chk({vecs[i].nm, "_signop"}, 64'(es),  64'(vecs[i].sop));
         chk({vecs[i].nm, "_pcsrc"},  64'(ep),  64'(vecs[i].pcs));
         chk({vecs[i].nm, "_regwr"},  64'(rws), 64'(vecs[i].rw));
         chk({vecs[i].nm, "_final"},  64'(fin), 64'(vecs[i].fin));
      end

      // ADD state walk with regwrite/pcwrite confined to WB
      do_reset();
      opcode = 11'b10001011000; mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("add_state", 64'(state), 64'(add_st[i]));
         chk("add_regwrite", 64'(regwrite), 64'(i == 3));
         chk("add_pcwrite", 64'(pcwrite), 64'(i == 3));
         @(posedge CLK); #1;
      end

      // LDUR with three wait cycles in MEM
      do_reset();
      opcode = 11'b11111000010;
      cyc = 0; mr_cnt = 0; m2r_seen = 1'b0;
      do begin
         mem_ready = !(cyc >= 3 && cyc < 6);
         @(negedge CLK);
         if (memread) mr_cnt++;
         if (state == 3'd4 && mem2reg) m2r_seen = 1'b1;
         cyc++;
         @(posedge CLK); #1;
      end while (state != 3'd0 && cyc < 20);
      chk("ldur_wait_cycles", 64'(cyc), 64'd8);
      chk("ldur_memread_len", 64'(mr_cnt), 64'd4);
      chk("ldur_mem2reg", 64'(m2r_seen), 64'd1);

      // FETCH timeout into sticky FAULT
      do_reset();
      mem_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge CLK);
         if (i == 4) chk("timeout_c4_state", 64'(state), 64'd0);
         if (i == 5) chk("timeout_c5_state", 64'(state), 64'd7);
         @(posedge CLK); #1;
      end
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("fault_sticky", 64'(fault), 64'd1);
         chk("fault_strobes", 64'(w_act[22:4]), 64'd0);
         @(posedge CLK); #1;
      end
      do_reset();
      @(negedge CLK);
      chk("fault_cleared", 64'(fault), 64'd0);
      @(posedge CLK); #1;

      // Reset in the middle of a STUR memory wait
      do_reset();
      opcode = 11'b11111000000; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin @(posedge CLK); #1; end
      mem_ready = 1'b0;
      @(negedge CLK);
      chk("stur_mem_memwrite", 64'(memwrite), 64'd1);
      #1 reset = 1'b1;
      #1;
      chk("stur_abort_memwrite", 64'(memwrite), 64'd0);
      chk("stur_abort_state", 64'(state), 64'd0);
      chk("stur_abort_pcwrite", 64'(pcwrite), 64'd0);
      @(posedge CLK); #1;
      reset = 1'b0;

`ifdef PERF_CNT_EN
      do_reset();
      for (int i = 0; i < 3; i++) run_instr(11'b10001011000, 1'b0, cyc, ea, es, ep, rws, fin);
      run_instr(11'b00010100000, 1'b0, cyc, ea, es, ep, rws, fin);
      chk("retired_count", 64'(retired), 64'd4);
`endif

      // Randomized cycles against the reference model
      do_reset();
      opcode = 11'd0;
      fault_cyc = 0;
      for (int n = 0; n < 3000; n++) begin
         if (m_ph == PH_D)
            opcode = ($urandom_range(7) == 0) ? 11'($urandom) : gen_op($urandom_range(10));
         mem_ready = ($urandom_range(3) != 0);
         zero = 1'($urandom);
         @(negedge CLK);
         chk("rand_outputs", 64'(w_act), 64'(exp_out(m_ph, m_c, zero, mem_ready, m_sh)));
         m_ret = m_ret + 32'(exp_out(m_ph, m_c, zero, mem_ready, m_sh) >> 20 & 23'd1);
         model_step();
         @(posedge CLK); #1;
`ifdef PERF_CNT_EN
         chk("rand_retired", 64'(retired), 64'(m_ret));
`endif
         if (m_ph == PH_X) fault_cyc++;
         if (fault_cyc > 2) begin
            fault_cyc = 0;
            do_reset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
